// File: rtl/rs_select_ctrl_if.sv
// Request/result handshake bundle for the result-select controller.
// Signal names are written from the controller's point of view.
interface rs_select_ctrl_if #(
   parameter int SIZE = 32,
   parameter int TAGW = 4
);
   logic            i_in_valid;
   logic            o_in_ready;
   logic [2:0]      i_in_op;
   logic            i_in_signed;
   logic [SIZE-1:0] i_in_a;
   logic [SIZE-1:0] i_in_b;
   logic [SIZE-1:0] i_in_alu;
   logic [TAGW-1:0] i_in_tag;
   logic            o_out_valid;
   logic            i_out_ready;
   logic [SIZE-1:0] o_out_data;
   logic [TAGW-1:0] o_out_tag;
   logic            o_out_taken;

   modport slave (
      input  i_in_valid, i_in_op, i_in_signed,
      input  i_in_a, i_in_b, i_in_alu, i_in_tag,
      output o_in_ready,
      output o_out_valid, o_out_data,
      output o_out_tag, o_out_taken,
      input  i_out_ready
   );

   modport master (
      output i_in_valid, i_in_op, i_in_signed,
      output i_in_a, i_in_b, i_in_alu, i_in_tag,
      input  o_in_ready,
      input  o_out_valid, o_out_data,
      input  o_out_tag, o_out_taken,
      output i_out_ready
   );
endinterface

// File: rtl/rs_select_ctrl.sv
// Result-select sequencer: 2-entry request queue, compare flags,
// mux select generation and held downstream result register.
module rs_select_ctrl #(
   parameter int SIZE = 32,
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            rst,
   rs_select_ctrl_if.slave bus,
   output logic [2:0]      o_sel,
   output logic            o_equal,
   output logic            o_greater,
   output logic            o_less,
   output logic            o_not_equal,
   output logic [SIZE-1:0] o_alu_result,
   input  logic [SIZE-1:0] i_mux_out,
   output logic            o_err_illegal
);

   typedef struct packed {
      logic [2:0]      op;
      logic            sgn;
      logic [SIZE-1:0] a;
      logic [SIZE-1:0] b;
      logic [SIZE-1:0] alu;
      logic [TAGW-1:0] tag;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EVAL = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_nxt;
   entry_t          r_q [2];
   logic            r_wp;
   logic            r_rp;
   logic [1:0]      r_cnt;
   entry_t          r_ex;
   logic [SIZE-1:0] r_out_data;
   logic [TAGW-1:0] r_out_tag;
   logic            r_out_taken;
   logic            r_err;

   entry_t w_in;
   logic   w_full;
   logic   w_empty;
   logic   w_push;
   logic   w_pop;
   logic   w_legal;
   logic   w_cmp;
   logic   w_out_valid;

   assign w_in = '{
      op:  bus.i_in_op,
      sgn: bus.i_in_signed,
      a:   bus.i_in_a,
      b:   bus.i_in_b,
      alu: bus.i_in_alu,
      tag: bus.i_in_tag
   };

   assign w_full  = (r_cnt == 2'd2);
   assign w_empty = (r_cnt == 2'd0);
   // A full queue refuses pushes even when a pop frees a slot
   assign w_push  = bus.i_in_valid && !w_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q[0] <= '0;
         r_q[1] <= '0;
         r_wp   <= 1'b0;
         r_rp   <= 1'b0;
         r_cnt  <= 2'd0;
      end else begin
         if (w_push) begin
            r_q[r_wp] <= w_in;
            r_wp      <= ~r_wp;
         end
         if (w_pop)
            r_rp <= ~r_rp;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_nxt;
   end

   always_comb begin
      w_nxt       = r_state;
      w_pop       = 1'b0;
      w_out_valid = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               w_nxt = S_EVAL;
            end
         end
         S_EVAL: w_nxt = S_DONE;
         S_DONE: begin
            w_out_valid = 1'b1;
            if (bus.i_out_ready) begin
               if (!w_empty) begin
                  w_pop = 1'b1;
                  w_nxt = S_EVAL;
               end else begin
                  w_nxt = S_IDLE;
               end
            end
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   assign w_legal = (r_ex.op <= 3'b100);
   assign w_cmp   = w_legal && (r_ex.op != 3'b011);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex        <= '0;
         r_out_data  <= '0;
         r_out_tag   <= '0;
         r_out_taken <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_pop)
            r_ex <= r_q[r_rp];
         if (r_state == S_EVAL) begin
            r_out_data  <= i_mux_out;
            r_out_tag   <= r_ex.tag;
            r_out_taken <= w_cmp && i_mux_out[0];
            if (!w_legal)
               r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      o_greater = (r_ex.a > r_ex.b);
      o_less    = (r_ex.a < r_ex.b);
      if (r_ex.sgn) begin
         o_greater = ($signed(r_ex.a) > $signed(r_ex.b));
         o_less    = ($signed(r_ex.a) < $signed(r_ex.b));
      end
   end

   // Illegal ops fall back to the PASS select
   always_comb begin
      o_sel = 3'b011;
      if ((r_state == S_EVAL) && w_legal)
         o_sel = r_ex.op;
   end

   assign o_equal      = (r_ex.a == r_ex.b);
   assign o_not_equal  = !o_equal;
   assign o_alu_result = r_ex.alu;
   assign o_err_illegal = r_err;

   assign bus.o_in_ready  = !w_full;
   assign bus.o_out_valid = w_out_valid;
   assign bus.o_out_data  = r_out_data;
   assign bus.o_out_tag   = r_out_tag;
   assign bus.o_out_taken = r_out_taken;

endmodule

// File: tb/tb_rs_select_ctrl.sv
// Directed bench for rs_select_ctrl with a behavioural result mux.
module tb_rs_select_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  sel;
   logic        eq, gt, lt, ne;
   logic [31:0] alu_res;
   logic [31:0] mux_out;
   logic        err;
   int          n_pass = 0;
   int          n_total = 0;

   rs_select_ctrl_if #(.SIZE(32), .TAGW(4)) bus ();

   rs_select_ctrl #(.SIZE(32), .TAGW(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .o_sel        (sel),
      .o_equal      (eq),
      .o_greater    (gt),
      .o_less       (lt),
      .o_not_equal  (ne),
      .o_alu_result (alu_res),
      .i_mux_out    (mux_out),
      .o_err_illegal(err)
   );

   always #5 clk = ~clk;

   always_comb begin
      mux_out = alu_res;
      case (sel)
         3'b000:  mux_out = {31'd0, eq};
         3'b001:  mux_out = {31'd0, gt};
         3'b010:  mux_out = {31'd0, lt};
         3'b100:  mux_out = {31'd0, ne};
         default: mux_out = alu_res;
      endcase
   end

   initial begin
      #400000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] alu, input logic [3:0] tag);
      bus.i_in_valid  = 1'b1;
      bus.i_in_op     = op;
      bus.i_in_signed = s;
      bus.i_in_a      = a;
      bus.i_in_b      = b;
      bus.i_in_alu    = alu;
      bus.i_in_tag    = tag;
   endtask

   task automatic run_one(input logic [2:0] op, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] alu, input logic [3:0] tag,
                          output logic [31:0] d, output logic [3:0] t,
                          output logic tk, output logic [2:0] esel,
                          output int lat);
      drive(op, s, a, b, alu, tag);
      step();
      bus.i_in_valid = 1'b0;
      lat  = 0;
      esel = 3'b111;
      for (int i = 0; i < 10; i++) begin
         esel = sel;
         step();
         lat++;
         if (bus.o_out_valid) break;
      end
      d  = bus.o_out_data;
      t  = bus.o_out_tag;
      tk = bus.o_out_taken;
   endtask

   logic [31:0] d;
   logic [3:0]  t;
   logic        tk;
   logic [2:0]  es;
   int          lat;
   int          hi;

   initial begin
      bus.i_in_valid  = 1'b0;
      bus.i_in_op     = 3'b000;
      bus.i_in_signed = 1'b0;
      bus.i_in_a      = '0;
      bus.i_in_b      = '0;
      bus.i_in_alu    = '0;
      bus.i_in_tag    = '0;
      bus.i_out_ready = 1'b1;
      #12;
      chk("rst_in_ready", bus.o_in_ready, 1);
      chk("rst_out_valid", bus.o_out_valid, 0);
      chk("rst_out_data", bus.o_out_data, 0);
      chk("rst_out_tag", bus.o_out_tag, 0);
      chk("rst_out_taken", bus.o_out_taken, 0);
      chk("rst_err", err, 0);
      chk("rst_flags", {eq, ne, gt, lt}, 4'b1000);
      chk("rst_alu", alu_res, 0);
      chk("rst_sel", sel, 3'b011);
      @(negedge clk);
      rst = 1'b0;
      step();

      // EQ then NE back to back
      drive(3'b000, 1'b0, 32'h5, 32'h5, 32'h0, 4'd1);
      step();
      drive(3'b100, 1'b0, 32'h5, 32'h5, 32'h0, 4'd2);
      step();
      bus.i_in_valid = 1'b0;
      chk("eq_eval_sel", sel, 3'b000);
      chk("eq_eval_valid", bus.o_out_valid, 0);
      step();
      chk("eq_valid", bus.o_out_valid, 1);
      chk("eq_res", {bus.o_out_data, bus.o_out_taken, bus.o_out_tag},
          {32'd1, 1'b1, 4'd1});
      step();
      chk("ne_eval_valid", bus.o_out_valid, 0);
      chk("ne_eval_sel", sel, 3'b100);
      step();
      chk("ne_valid", bus.o_out_valid, 1);
      chk("ne_res", {bus.o_out_data, bus.o_out_taken, bus.o_out_tag},
          {32'd0, 1'b0, 4'd2});
      step();
      chk("ne_drop", bus.o_out_valid, 0);

      run_one(3'b001, 1'b0, 32'hFFFF_FFFF, 32'h1, 0, 4'd3, d, t, tk, es, lat);
      chk("gtu_lat", lat, 2);
      chk("gtu_res", {d, tk, t}, {32'd1, 1'b1, 4'd3});
      run_one(3'b001, 1'b1, 32'hFFFF_FFFF, 32'h1, 0, 4'd4, d, t, tk, es, lat);
      chk("gts_res", {d, tk, t}, {32'd0, 1'b0, 4'd4});
      run_one(3'b010, 1'b1, 32'hFFFF_FFFF, 32'h1, 0, 4'd5, d, t, tk, es, lat);
      chk("lts_res", {d, tk, t}, {32'd1, 1'b1, 4'd5});
      run_one(3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 0, 4'd6, d, t, tk, es, lat);
      chk("ltu_res", {d, tk}, {32'd0, 1'b0});

      run_one(3'b011, 1'b0, 0, 0, 32'hDEAD_BEEF, 4'd7, d, t, tk, es, lat);
      chk("pass_sel", es, 3'b011);
      chk("pass_res", {d, tk, t}, {32'hDEAD_BEEF, 1'b0, 4'd7});
      chk("pass_alu", alu_res, 32'hDEAD_BEEF);
      chk("pass_err", err, 0);
      run_one(3'b110, 1'b0, 32'h1, 32'h1, 32'h55, 4'd8, d, t, tk, es, lat);
      chk("ill_sel", es, 3'b011);
      chk("ill_res", {d, tk, t}, {32'h55, 1'b0, 4'd8});
      chk("ill_err", err, 1);
      run_one(3'b000, 1'b0, 32'h3, 32'h4, 0, 4'd9, d, t, tk, es, lat);
      chk("post_ill_res", {d, tk}, {32'd0, 1'b0});
      chk("err_sticky", err, 1);
      step();

      // back-pressure
      bus.i_out_ready = 1'b0;
      chk("bp_rdy0", bus.o_in_ready, 1);
      drive(3'b000, 1'b0, 32'h7, 32'h7, 0, 4'd5);
      step();
      chk("bp_rdy1", bus.o_in_ready, 1);
      drive(3'b011, 1'b0, 0, 0, 32'h1234, 4'd6);
      step();
      chk("bp_rdy2", bus.o_in_ready, 1);
      drive(3'b011, 1'b0, 0, 0, 32'hABCD, 4'd7);
      step();
      drive(3'b011, 1'b0, 0, 0, 32'hFFFF, 4'd8);
      chk("bp_rdy3", bus.o_in_ready, 0);
      chk("bp_hold0", {bus.o_out_valid, bus.o_out_data, bus.o_out_tag},
          {1'b1, 32'd1, 4'd5});
      step();
      step();
      step();
      chk("bp_rdy4", bus.o_in_ready, 0);
      chk("bp_hold1", {bus.o_out_valid, bus.o_out_data, bus.o_out_tag},
          {1'b1, 32'd1, 4'd5});
      bus.i_in_valid  = 1'b0;
      bus.i_out_ready = 1'b1;
      step();
      chk("dr_gap1", bus.o_out_valid, 0);
      step();
      chk("dr_b", {bus.o_out_valid, bus.o_out_data, bus.o_out_tag},
          {1'b1, 32'h1234, 4'd6});
      step();
      chk("dr_gap2", bus.o_out_valid, 0);
      step();
      chk("dr_c", {bus.o_out_valid, bus.o_out_data, bus.o_out_tag},
          {1'b1, 32'hABCD, 4'd7});
      step();
      chk("dr_end", {bus.o_out_valid, bus.o_in_ready}, 2'b01);
      step();
      chk("dr_none", bus.o_out_valid, 0);

      // reset during EVAL with work queued
      drive(3'b000, 1'b0, 32'h1, 32'h1, 0, 4'hA);
      step();
      drive(3'b000, 1'b0, 32'h2, 32'h2, 0, 4'hB);
      step();
      drive(3'b000, 1'b0, 32'h3, 32'h3, 0, 4'hC);
      chk("mr_eval_sel", sel, 3'b000);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_rdy", bus.o_in_ready, 1);
      chk("mr_valid", bus.o_out_valid, 0);
      chk("mr_err", err, 0);
      bus.i_in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.o_out_valid) hi++;
      end
      chk("mr_no_stale", hi, 0);
      chk("mr_tag", bus.o_out_tag, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
